// File: rtl/load_store_unit_pkg.sv
// Shared constants and helpers for the RV32I load/store unit: state and funct3
// encodings plus the size/alignment/lane arithmetic used when a request is accepted.
package load_store_unit_pkg;

  localparam int REGWIDTH = 32;

  localparam logic [1:0] LSU_IDLE   = 2'd0;
  localparam logic [1:0] LSU_ACCESS = 2'd1;
  localparam logic [1:0] LSU_RESP   = 2'd2;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } access_size_e;

  // Only funct3[1:0] carries the size; any code with bit 1 set is treated as a word.
  function automatic access_size_e decode_size(input logic [1:0] size_code);
    if (size_code[1])      return SIZE_WORD;
    else if (size_code[0]) return SIZE_HALF;
    else                   return SIZE_BYTE;
  endfunction

  function automatic logic is_misaligned(input access_size_e size, input logic [1:0] addr_lo);
    case (size)
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return |addr_lo;
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input access_size_e size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 4'b0001 << addr_lo;
      SIZE_HALF: return 4'b0011 << addr_lo;
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate_wdata(input access_size_e size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: return {4{data[7:0]}};
      SIZE_HALF: return {2{data[15:0]}};
      default:   return data;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_extend.sv
// Lane select plus sign/zero extension of a read word; kept separate so a
// future MMIO read path can reuse it.
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    case (funct3)
      LB:      data = {{24{byte_sel[7]}}, byte_sel};
      LH:      data = {{16{half_sel[15]}}, half_sel};
      LBU:     data = {24'h0, byte_sel};
      LHU:     data = {16'h0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one RV32I load or store per start pulse over a
// ready-handshaked data port, stalling the core until done.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [2:0]          funct3,
  input  logic [REGWIDTH-1:0] ALUResult,
  input  logic [REGWIDTH-1:0] ReadData2,
  output logic                busy,
  output logic                done,
  output logic [REGWIDTH-1:0] LoadData,
  output logic                misalign,
  output logic                err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [29:0]         mem_addr,
  output logic [3:0]          mem_wstrb,
  output logic [31:0]         mem_wdata,
  input  logic                mem_ready,
  input  logic [31:0]         mem_rdata
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [1:0]   state;
  logic [7:0]   wait_cnt;
  logic [2:0]   funct3_q;
  logic [1:0]   addr_lo_q;
  logic [31:0]  ext_data;
  access_size_e req_size;
  logic         req_valid;
  logic         req_store;
  logic         req_misaligned;

  always_comb begin
    req_size       = decode_size(funct3[1:0]);
    req_valid      = start & (MemRead | MemWrite);
    req_store      = MemWrite & ~MemRead;
    req_misaligned = is_misaligned(req_size, ALUResult[1:0]);
  end

  assign busy = start | (state != LSU_IDLE);

  load_extend u_extend (
    .funct3  (funct3_q),
    .addr_lo (addr_lo_q),
    .word    (mem_rdata),
    .data    (ext_data)
  );

  // The request fields are latched at acceptance so the core may move on while
  // the port holds address, strobes and data stable until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LSU_IDLE;
      wait_cnt  <= 8'd0;
      funct3_q  <= 3'd0;
      addr_lo_q <= 2'd0;
      done      <= 1'b0;
      misalign  <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 30'd0;
      mem_wstrb <= 4'd0;
      mem_wdata <= 32'd0;
      LoadData  <= '0;
    end else begin
      done     <= 1'b0;
      misalign <= 1'b0;
      err      <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (req_valid) begin
            funct3_q  <= funct3;
            addr_lo_q <= ALUResult[1:0];
            mem_we    <= req_store;
            mem_addr  <= ALUResult[31:2];
            mem_wstrb <= req_store ? byte_enables(req_size, ALUResult[1:0]) : 4'd0;
            mem_wdata <= replicate_wdata(req_size, ReadData2[31:0]);
            wait_cnt  <= 8'd0;
            if (req_misaligned) begin
              state    <= LSU_RESP;
              done     <= 1'b1;
              misalign <= 1'b1;
            end else begin
              state   <= LSU_ACCESS;
              mem_req <= 1'b1;
            end
          end
        end
        LSU_ACCESS: begin
          if (mem_ready) begin
            state   <= LSU_RESP;
            mem_req <= 1'b0;
            done    <= 1'b1;
            if (!mem_we) LoadData <= ext_data;
          end else if (wait_cnt == TIMEOUT_CNT) begin
            state   <= LSU_RESP;
            mem_req <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        LSU_RESP: state <= LSU_IDLE;
        default:  state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized bench for load_store_unit; expectations come from a
// byte-arithmetic model of the access rules kept in this file.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult;
  logic [31:0] ReadData2;
  logic        busy;
  logic        done;
  logic [31:0] LoadData;
  logic        misalign;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_load = 32'd0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .funct3    (funct3),
    .ALUResult (ALUResult),
    .ReadData2 (ReadData2),
    .busy      (busy),
    .done      (done),
    .LoadData  (LoadData),
    .misalign  (misalign),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllIdle(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_req"}, mem_req, 0);
    checkOutput({tag, "_we"}, mem_we, 0);
    checkOutput({tag, "_addr"}, mem_addr, 0);
    checkOutput({tag, "_strb"}, mem_wstrb, 0);
    checkOutput({tag, "_wdata"}, mem_wdata, 0);
    checkOutput({tag, "_misalign"}, misalign, 0);
    checkOutput({tag, "_err"}, err, 0);
    checkOutput({tag, "_load"}, LoadData, exp_load);
  endtask

  // One complete request; memory answers after 'delay' request cycles.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] data,
                               input int delay, input logic [31:0] rdata);
    int          size;
    int          lane;
    int          shift;
    int          exp_cycle;
    logic        mis;
    logic        exp_err;
    logic        is_store;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] val;
    logic [31:0] mask;

    size      = f3[1] ? 4 : (f3[0] ? 2 : 1);
    lane      = int'(addr % 32'd4);
    mis       = (lane % size) != 0;
    is_store  = wr && !rd;
    exp_strb  = is_store ? 4'(((1 << size) - 1) << lane) : 4'h0;
    exp_wdata = (size == 1) ? {24'h0, data[7:0]} * 32'h01010101 :
                (size == 2) ? {16'h0, data[15:0]} * 32'h00010001 : data;
    exp_err   = !mis && (delay > TO);
    exp_cycle = mis ? 1 : (exp_err ? TO + 2 : delay + 2);

    start     = 1'b1;
    MemRead   = rd;
    MemWrite  = wr;
    funct3    = f3;
    ALUResult = addr;
    ReadData2 = data;
    mem_ready = 1'b0;
    mem_rdata = rdata;
    #1;
    checkOutput("busy_on_start", busy, 1);
    advance();
    start     = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    funct3    = 3'($urandom);
    ALUResult = $urandom;
    ReadData2 = $urandom;

    for (int c = 1; c <= exp_cycle; c++) begin
      mem_ready = (c - 1 == delay);
      #1;
      checkOutput("busy_active", busy, 1);
      if (c < exp_cycle) begin
        checkOutput("done_early", done, 0);
        checkOutput("load_hold", LoadData, exp_load);
        checkOutput("mem_req_held", mem_req, mis ? 0 : 1);
        if (!mis) begin
          checkOutput("mem_addr", mem_addr, addr >> 2);
          checkOutput("mem_we", mem_we, is_store);
          checkOutput("mem_wstrb", mem_wstrb, exp_strb);
          if (is_store) checkOutput("mem_wdata", mem_wdata, exp_wdata);
        end
        advance();
      end else begin
        if (rd && !mis && !exp_err) begin
          if (size == 4) begin
            val = rdata;
          end else begin
            shift = (size == 1) ? 8 * lane : 16 * (lane / 2);
            mask  = (size == 1) ? 32'hFF : 32'hFFFF;
            val   = (rdata >> shift) & mask;
            if (!f3[2] && ((val & ((mask >> 1) + 1)) != 0)) val = val | ~mask;
          end
          exp_load = val;
        end
        checkOutput("done", done, 1);
        checkOutput("misalign", misalign, mis);
        checkOutput("err", err, exp_err);
        checkOutput("mem_req_dropped", mem_req, 0);
        checkOutput("load_data", LoadData, exp_load);
      end
    end
    mem_ready = 1'b0;
    advance();
    #1;
    checkOutput("done_single", done, 0);
    checkOutput("busy_released", busy, 0);
  endtask

  initial begin
    int          sel;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [2:0]  load_codes [5];

    load_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    rst       = 1'b1;
    start     = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    funct3    = 3'd0;
    ALUResult = 32'd0;
    ReadData2 = 32'd0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    advance();
    advance();
    rst = 1'b0;
    #1;
    checkAllIdle("reset");

    // Directed cases from the access rules.
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'hDEADBEEF, 0, 32'h0);
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 32'h80112233);
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0, 0, 32'h80112233);
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h0000_1002, 32'h0, 0, 32'h80112233);
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000ABCD, 0, 32'h0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 0, 32'h12345678);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 3, 32'hCAFEF00D);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 100, 32'h11111111);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_6006, 32'h0, TO, 32'h8001_7FFF);
    applyStimulus(1'b1, 1'b1, 3'b000, 32'h0000_7001, 32'hFFFFFFFF, 1, 32'h0000_4200);
    applyStimulus(1'b1, 1'b0, 3'b111, 32'h0000_8008, 32'h0, 0, 32'h89ABCDEF);

    // A start with no direction must not launch anything.
    start   = 1'b1;
    funct3  = 3'b010;
    #1;
    checkOutput("ignored_busy_start", busy, 1);
    advance();
    start = 1'b0;
    #1;
    checkOutput("ignored_busy", busy, 0);
    checkOutput("ignored_req", mem_req, 0);
    advance();
    checkOutput("ignored_done", done, 0);

    // Reset during the second wait cycle abandons the access silently.
    start     = 1'b1;
    MemRead   = 1'b1;
    funct3    = 3'b010;
    ALUResult = 32'h0000_9000;
    advance();
    start   = 1'b0;
    MemRead = 1'b0;
    #1;
    checkOutput("rst_pre_req", mem_req, 1);
    advance();
    rst = 1'b1;
    advance();
    rst      = 1'b0;
    exp_load = 32'd0;
    #1;
    checkAllIdle("mid_reset");
    advance();
    checkOutput("mid_reset_no_done", done, 0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_A004, 32'h0, 1, 32'h0BADC0DE);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(1, 3));
      rd  = sel[0];
      wr  = sel[1];
      if (wr && !rd) f3 = 3'($urandom_range(0, 2));
      else           f3 = load_codes[$urandom_range(0, 4)];
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = (f3[1:0] == 2'b00) ? addr[1:0] :
                                                 (f3[1:0] == 2'b01) ? {addr[1], 1'b0} : 2'b00;
      applyStimulus(rd, wr, f3, addr, $urandom, int'($urandom_range(0, TO + 2)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
